// File: rtl/wb_load_unit.sv
// Writeback stage that drives the register file write port.
// ALU results commit one cycle after acceptance. Loads issue one word read
// to data memory, then align and extend the returned data before committing.
// Misaligned loads, illegal load encodings and memory timeouts raise a
// one-cycle error pulse and are never written back.
module wb_load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_wb_sel,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_reg_write,
  output logic [4:0]  o_write_rd,
  output logic [31:0] o_write_data,
  output logic        o_load_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [4:0]    rd_q;
  logic          reg_write_q;
  logic [2:0]    funct3_q;
  logic [1:0]    offset_q;

  logic          load_bad;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_data;

  assign o_ready = (state == IDLE);

  // Decide whether the incoming load has an illegal encoding or a misaligned address
  always_comb begin
    load_bad = 1'b0;
    case (i_funct3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = i_alu_result[0];
      F3_LW:         load_bad = (i_alu_result[1:0] != 2'b00);
      default:       load_bad = 1'b1;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_data = 32'h0000_0000;
    case (offset_q)
      2'd0:    load_byte = i_dmem_rdata[7:0];
      2'd1:    load_byte = i_dmem_rdata[15:8];
      2'd2:    load_byte = i_dmem_rdata[23:16];
      default: load_byte = i_dmem_rdata[31:24];
    endcase
    load_half = offset_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (funct3_q)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LBU:  load_data = {24'h000000, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LHU:  load_data = {16'h0000, load_half};
      default: load_data = i_dmem_rdata;
    endcase
  end

  // Writeback FSM: commits ALU results, runs loads and flags errors/timeouts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      o_dmem_req   <= 1'b0;
      o_dmem_addr  <= 32'h0000_0000;
      o_reg_write  <= 1'b0;
      o_write_rd   <= 5'd0;
      o_write_data <= 32'h0000_0000;
      o_load_err   <= 1'b0;
    end else begin
      o_reg_write <= 1'b0;
      o_load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (!i_wb_sel) begin
              o_reg_write  <= i_reg_write & (i_rd != 5'd0);
              o_write_rd   <= i_rd;
              o_write_data <= i_alu_result;
            end else if (load_bad) begin
              o_load_err <= 1'b1;
            end else begin
              rd_q        <= i_rd;
              reg_write_q <= i_reg_write;
              funct3_q    <= i_funct3;
              offset_q    <= i_alu_result[1:0];
              o_dmem_addr <= {i_alu_result[31:2], 2'b00};
              o_dmem_req  <= 1'b1;
              wait_cnt    <= '0;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_dmem_ack) begin
            o_dmem_req   <= 1'b0;
            o_reg_write  <= reg_write_q & (rd_q != 5'd0);
            o_write_rd   <= rd_q;
            o_write_data <= load_data;
            state        <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            o_dmem_req <= 1'b0;
            o_load_err <= 1'b1;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
